ddr3_cke_lane_ctrl: RTL and testbench

//  Fabric-side driver for the DDR3 CKE output lane. It sits directly upstream of the CKE IOD and feeds it:
//  - 4:1 gearbox TX/OE data, one word per FAB_CLK.
//  - A CKE sequencer: init hold-low, active, and power-down entry/exit with tCKE enforcement.
//  - A delay-line step engine driving the IOD MOVE/DIRECTION/LOAD controls, with tap tracking and out-of-range abort.

---
 rtl/ddr3_cke_lane_ctrl_if.sv | 33 +++
 rtl/ddr3_cke_lane_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ddr3_cke_lane_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_cke_lane_ctrl_if.sv
// Control/status bundle between the fabric user and the DDR3 CKE lane driver.
// Master drives requests and the IOD range flag; slave (the lane driver) drives lane data and status.
interface ddr3_cke_lane_ctrl_if;
    logic       phy_en;
    logic       pd_req;
    logic       init_done;
    logic       pd_ack;
    logic [3:0] tx_data_0;
    logic [3:0] oe_data_0;
    logic       dly_req;
    logic       dly_dir;
    logic [7:0] dly_steps;
    logic       dly_load_req;
    logic       dly_busy;
    logic       dly_err;
    logic [7:0] dly_tap;
    logic       delay_line_move_0;
    logic       delay_line_direction_0;
    logic       delay_line_load_0;
    logic       delay_line_out_of_range_0;

    modport master (
        output phy_en, pd_req, dly_req, dly_dir, dly_steps, dly_load_req, delay_line_out_of_range_0,
        input  init_done, pd_ack, tx_data_0, oe_data_0, dly_busy, dly_err, dly_tap,
               delay_line_move_0, delay_line_direction_0, delay_line_load_0
    );

    modport slave (
        input  phy_en, pd_req, dly_req, dly_dir, dly_steps, dly_load_req, delay_line_out_of_range_0,
        output init_done, pd_ack, tx_data_0, oe_data_0, dly_busy, dly_err, dly_tap,
               delay_line_move_0, delay_line_direction_0, delay_line_load_0
    );
endinterface

// File: rtl/ddr3_cke_lane_ctrl.sv
// Fabric-side CKE lane driver: gearbox data, CKE init/power-down sequencer with tCKE, delay-line step engine.
// Outputs decode registered state (one cycle after the sampling edge); no backpressure, step/load requests while busy are dropped.
module ddr3_cke_lane_ctrl #(
    parameter int unsigned INIT_CKE_LOW_CYC = 50000,
    parameter int unsigned TCKE_MIN_CYC     = 4,
    parameter int unsigned DLY_MAX_TAP      = 127
) (
    input  logic                  clk,
    input  logic                  rst,
    ddr3_cke_lane_ctrl_if.slave   lane
);
    localparam int unsigned INIT_W = $clog2(INIT_CKE_LOW_CYC + 1);
    localparam int unsigned LVL_W  = $clog2(TCKE_MIN_CYC + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CKE_LOW_CYC);
    localparam logic [LVL_W-1:0]  LVL_MAX   = LVL_W'(TCKE_MIN_CYC);
    localparam logic [LVL_W-1:0]  LVL_OK    = LVL_W'(TCKE_MIN_CYC - 1);
    localparam logic [7:0]        TAP_MAX   = 8'(DLY_MAX_TAP);

    typedef enum logic [1:0] {CKE_IDLE, CKE_INIT, CKE_ACTIVE, CKE_PD} cke_state_t;
    typedef enum logic [2:0] {DLY_IDLE, DLY_LOAD, DLY_LOAD_WAIT, DLY_SETUP, DLY_PULSE, DLY_GAP} dly_state_t;

    cke_state_t        cke_st, cke_nxt;
    logic [INIT_W-1:0] init_cnt;
    logic [LVL_W-1:0]  lvl_cnt;
    logic              tcke_ok;
    logic              cke;
    logic              init_done;
    logic              pd_ack;
    logic [3:0]        oe_q;

    dly_state_t        dly_st, dly_nxt;
    logic              dir_q;
    logic [7:0]        steps_q;
    logic [7:0]        tap_q;
    logic              err_q;
    logic              step_ok;
    logic              dly_abort;
    logic              busy;
    logic              move;
    logic              load;

    // lvl_cnt counts completed cycles at the current level, so the cycle in
    // progress completes tCKE once it has reached TCKE_MIN_CYC-1.
    assign tcke_ok = (lvl_cnt >= LVL_OK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cke_st <= CKE_IDLE;
        else     cke_st <= cke_nxt;
    end

    always_comb begin
        cke_nxt = cke_st;
        if (!lane.phy_en) begin
            cke_nxt = CKE_IDLE;
        end else begin
            case (cke_st)
                CKE_IDLE:   cke_nxt = CKE_INIT;
                CKE_INIT:   if (init_cnt == INIT_LAST) cke_nxt = CKE_ACTIVE;
                CKE_ACTIVE: if (lane.pd_req && tcke_ok) cke_nxt = CKE_PD;
                CKE_PD:     if (!lane.pd_req && tcke_ok) cke_nxt = CKE_ACTIVE;
                default:    cke_nxt = CKE_IDLE;
            endcase
        end
    end

    always_comb begin
        cke       = 1'b0;
        init_done = 1'b0;
        pd_ack    = 1'b0;
        case (cke_st)
            CKE_ACTIVE: begin
                cke       = 1'b1;
                init_done = 1'b1;
            end
            CKE_PD: begin
                init_done = 1'b1;
                pd_ack    = (lvl_cnt == LVL_MAX);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= '0;
            lvl_cnt  <= '0;
            oe_q     <= 4'h0;
        end else begin
            oe_q     <= 4'hF;
            init_cnt <= (cke_st == CKE_INIT && cke_nxt == CKE_INIT) ? init_cnt + 1'b1 : '0;
            if ((cke_nxt == CKE_ACTIVE) != cke) lvl_cnt <= '0;
            else if (lvl_cnt != LVL_MAX)        lvl_cnt <= lvl_cnt + 1'b1;
        end
    end

    assign lane.tx_data_0 = {4{cke}};
    assign lane.oe_data_0 = oe_q;
    assign lane.init_done = init_done;
    assign lane.pd_ack    = pd_ack;

    // Range is checked before every pulse so the tap never leaves [0, DLY_MAX_TAP].
    assign step_ok   = dir_q ? (tap_q < TAP_MAX) : (tap_q != 8'd0);
    assign dly_abort = ((dly_st == DLY_GAP) && lane.delay_line_out_of_range_0) ||
                       (((dly_st == DLY_SETUP) || (dly_st == DLY_GAP)) && (steps_q != 8'd0) && !step_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dly_st <= DLY_IDLE;
        else     dly_st <= dly_nxt;
    end

    always_comb begin
        dly_nxt = dly_st;
        case (dly_st)
            DLY_IDLE: begin
                if (lane.dly_load_req) dly_nxt = DLY_LOAD;
                else if (lane.dly_req) dly_nxt = DLY_SETUP;
            end
            DLY_LOAD:      dly_nxt = DLY_LOAD_WAIT;
            DLY_LOAD_WAIT: dly_nxt = DLY_IDLE;
            DLY_SETUP, DLY_GAP: begin
                if (dly_abort || steps_q == 8'd0) dly_nxt = DLY_IDLE;
                else                              dly_nxt = DLY_PULSE;
            end
            DLY_PULSE:     dly_nxt = DLY_GAP;
            default:       dly_nxt = DLY_IDLE;
        endcase
    end

    always_comb begin
        busy = (dly_st != DLY_IDLE);
        move = (dly_st == DLY_PULSE);
        load = (dly_st == DLY_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q   <= 1'b0;
            steps_q <= 8'd0;
            tap_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            if (dly_st == DLY_IDLE) begin
                if (lane.dly_load_req) begin
                    tap_q <= 8'd0;
                    err_q <= 1'b0;
                end else if (lane.dly_req) begin
                    dir_q   <= lane.dly_dir;
                    steps_q <= lane.dly_steps;
                    err_q   <= 1'b0;
                end
            end
            if (dly_st == DLY_PULSE) begin
                tap_q   <= dir_q ? tap_q + 1'b1 : tap_q - 1'b1;
                steps_q <= steps_q - 1'b1;
            end
            if (dly_abort) err_q <= 1'b1;
        end
    end

    assign lane.dly_busy               = busy;
    assign lane.dly_err                = err_q;
    assign lane.dly_tap                = tap_q;
    assign lane.delay_line_move_0      = move;
    assign lane.delay_line_direction_0 = dir_q;
    assign lane.delay_line_load_0      = load;
endmodule

// File: tb/tb_ddr3_cke_lane_ctrl.sv
// Bench for the CKE lane driver: directed corner cases plus randomized traffic against a cycle-count model.
module tb_ddr3_cke_lane_ctrl;
    localparam int INIT = 10;
    localparam int TCKE = 4;
    localparam int MAXT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddr3_cke_lane_ctrl_if lane();

    ddr3_cke_lane_ctrl #(
        .INIT_CKE_LOW_CYC(INIT),
        .TCKE_MIN_CYC    (TCKE),
        .DLY_MAX_TAP     (MAXT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .lane (lane)
    );

    int   n_pass = 0;
    int   n_chk  = 0;
    int   m_tap;
    logic m_dir;
    int   off_cnt;

    // CKE reference: edge count, edge at which PHY_EN was first seen, edge of last CKE change.
    int   n, en_at, last_chg;
    logic m_cke, m_done, m_oe;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= 0; en_at <= -1; last_chg <= 0;
            m_cke <= 1'b0; m_done <= 1'b0; m_oe <= 1'b0;
        end else begin
            n    <= n + 1;
            m_oe <= 1'b1;
            if (!lane.phy_en) begin
                m_cke <= 1'b0; m_done <= 1'b0; en_at <= -1;
            end else if (en_at < 0) begin
                en_at <= n + 1;
            end else if (!m_done) begin
                if (n + 1 - en_at == INIT + 1) begin
                    m_cke <= 1'b1; m_done <= 1'b1; last_chg <= n + 1;
                end
            end else if (m_cke && lane.pd_req && (n + 1 - last_chg) >= TCKE) begin
                m_cke <= 1'b0; last_chg <= n + 1;
            end else if (!m_cke && !lane.pd_req && (n + 1 - last_chg) >= TCKE) begin
                m_cke <= 1'b1; last_chg <= n + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic cke_check();
        logic exp_ack;
        exp_ack = m_done && !m_cke && ((n - last_chg) >= TCKE);
        chk("cke_tx", lane.tx_data_0, {4{m_cke}});
        chk("cke_init_done", lane.init_done, m_done);
        chk("cke_pd_ack", lane.pd_ack, exp_ack);
        chk("cke_oe", lane.oe_data_0, m_oe ? 4'hF : 4'h0);
    endtask

    task automatic init_seq();
        lane.phy_en = 1'b1;
        for (int k = 0; k <= 11; k++) begin
            @(negedge clk);
            chk("init_tx", lane.tx_data_0, (k == 11) ? 4'hF : 4'h0);
            chk("init_done", lane.init_done, (k == 11) ? 1 : 0);
            chk("init_oe", lane.oe_data_0, 4'hF);
        end
    endtask

    task automatic do_load(input bit with_step);
        lane.dly_load_req = 1'b1;
        if (with_step) begin
            lane.dly_req   = 1'b1;
            lane.dly_dir   = 1'b1;
            lane.dly_steps = 8'd3;
        end
        @(negedge clk);
        lane.dly_load_req = 1'b0;
        lane.dly_req      = 1'b0;
        chk("load_pulse", {lane.delay_line_load_0, lane.dly_busy, lane.delay_line_move_0}, 3'b110);
        @(negedge clk);
        chk("load_wait", {lane.delay_line_load_0, lane.dly_busy, lane.delay_line_move_0}, 3'b010);
        @(negedge clk);
        chk("load_idle", lane.dly_busy, 1'b0);
        chk("load_tap", lane.dly_tap, 8'd0);
        chk("load_err", lane.dly_err, 1'b0);
        chk("load_dir", lane.delay_line_direction_0, m_dir);
        m_tap = 0;
    endtask

    // Expected outcome from the rules: moves limited by range room and the range-flag step.
    task automatic do_step(input logic dir, input int steps, input int oor_at, input bit noise);
        int   c, moves, busy_cyc, exp_moves, allowed, room;
        logic exp_err;
        bit   seq_ok, dir_ok, done, pend, hold;
        room    = dir ? (MAXT - m_tap) : m_tap;
        allowed = (steps < room) ? steps : room;
        if (oor_at >= 1 && oor_at <= allowed) begin
            exp_moves = oor_at; exp_err = 1'b1;
        end else begin
            exp_moves = allowed; exp_err = (allowed < steps);
        end
        lane.dly_req   = 1'b1;
        lane.dly_dir   = dir;
        lane.dly_steps = 8'(steps);
        @(negedge clk);
        lane.dly_req = 1'b0;
        c = 0; moves = 0; busy_cyc = 0;
        seq_ok = 1; dir_ok = 1; done = 0; pend = 0; hold = 0;
        while (!done && c < 1000) begin
            c++;
            if (hold) begin lane.delay_line_out_of_range_0 = 1'b0; hold = 0; end
            if (pend) begin lane.delay_line_out_of_range_0 = 1'b1; pend = 0; hold = 1; end
            if (noise && c == 1) begin
                lane.dly_req = 1'b1; lane.dly_load_req = 1'b1; lane.dly_dir = ~dir;
            end else begin
                lane.dly_req = 1'b0; lane.dly_load_req = 1'b0;
            end
            if (lane.dly_busy) begin
                busy_cyc++;
                if (lane.delay_line_direction_0 !== dir) dir_ok = 0;
                if (lane.delay_line_move_0) begin
                    moves++;
                    if (c != 2 * moves) seq_ok = 0;
                    if (moves == oor_at) pend = 1;
                end
            end else begin
                done = 1;
            end
            if (!done) @(negedge clk);
        end
        lane.delay_line_out_of_range_0 = 1'b0;
        lane.dly_req = 1'b0; lane.dly_load_req = 1'b0;
        chk("step_done", done, 1'b1);
        chk("step_moves", moves, exp_moves);
        chk("step_busy", busy_cyc, 1 + 2 * exp_moves);
        chk("step_spacing", seq_ok, 1'b1);
        chk("step_dir", dir_ok, 1'b1);
        m_tap = dir ? m_tap + exp_moves : m_tap - exp_moves;
        m_dir = dir;
        chk("step_tap", lane.dly_tap, m_tap);
        chk("step_err", lane.dly_err, exp_err);
    endtask

    initial begin
        rst = 1'b1;
        lane.phy_en = 1'b0; lane.pd_req = 1'b0;
        lane.dly_req = 1'b0; lane.dly_dir = 1'b0; lane.dly_steps = 8'd0; lane.dly_load_req = 1'b0;
        lane.delay_line_out_of_range_0 = 1'b0;
        m_tap = 0; m_dir = 1'b0; off_cnt = 0;
        repeat (2) @(negedge clk);
        chk("rst_cke", {lane.tx_data_0, lane.oe_data_0, lane.init_done, lane.pd_ack}, 10'h0);
        chk("rst_dly", {lane.dly_busy, lane.dly_err, lane.dly_tap}, 10'h0);
        chk("rst_iod", {lane.delay_line_move_0, lane.delay_line_direction_0, lane.delay_line_load_0}, 3'h0);
        rst = 1'b0;
        repeat (2) begin @(negedge clk); cke_check(); end

        init_seq();
        lane.pd_req = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            chk("pd_tx", lane.tx_data_0, (j < 4) ? 4'hF : 4'h0);
            chk("pd_ack", lane.pd_ack, (j >= 8) ? 1 : 0);
        end
        lane.pd_req = 1'b0;
        @(negedge clk);
        chk("pd_exit_tx", lane.tx_data_0, 4'hF);
        chk("pd_exit_ack", lane.pd_ack, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) lane.pd_req = ~lane.pd_req;
            if (off_cnt > 0) begin
                off_cnt--;
                if (off_cnt == 0) lane.phy_en = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                lane.phy_en = 1'b0;
                off_cnt = int'($urandom_range(1, 3));
            end
            @(negedge clk);
            cke_check();
        end

        do_load(1'b0);
        do_step(1'b1, 3, 0, 1'b0);
        chk("dir_tap3", lane.dly_tap, 8'd3);
        do_step(1'b0, 2, 0, 1'b0);
        do_step(1'b0, 5, 0, 1'b0);
        chk("low_abort_tap", lane.dly_tap, 8'd0);
        do_load(1'b0);
        do_step(1'b1, 6, 2, 1'b0);
        chk("oor_tap", lane.dly_tap, 8'd2);
        do_step(1'b1, 0, 0, 1'b0);
        do_load(1'b1);
        do_step(1'b1, 20, 0, 1'b1);
        chk("high_abort_tap", lane.dly_tap, 8'(MAXT));

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0)
                do_load(1'($urandom_range(0, 1)));
            else
                do_step(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
                        $urandom_range(0, 3) == 0);
        end

        lane.phy_en = 1'b1; lane.pd_req = 1'b1;
        repeat (30) @(negedge clk);
        cke_check();
        chk("pre_rst_ack", lane.pd_ack, 1'b1);
        do_load(1'b0);
        lane.dly_req = 1'b1; lane.dly_dir = 1'b1; lane.dly_steps = 8'd10;
        @(negedge clk);
        lane.dly_req = 1'b0;
        for (int i = 0; i < 20 && !lane.delay_line_move_0; i++) @(negedge clk);
        chk("rst_pulse_seen", lane.delay_line_move_0, 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_move", lane.delay_line_move_0, 1'b0);
        chk("arst_tx", lane.tx_data_0, 4'h0);
        chk("arst_oe", lane.oe_data_0, 4'h0);
        chk("arst_ack", lane.pd_ack, 1'b0);
        chk("arst_dly", {lane.dly_busy, lane.dly_tap}, 9'h0);
        m_tap = 0; m_dir = 1'b0;
        @(negedge clk);
        rst = 1'b0; lane.pd_req = 1'b0;
        init_seq();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
